// File: rtl/mxnbit_set_packer_pkg.sv
// Shared mxnbit constants: packer state encoding and the out_count width
// expression used by the set packer and the mXn gate wrappers.
package mxnbit_set_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Bits needed to hold a set count of 0..sets.
  // Clamped to 1 so an illegal sets value still elaborates far enough for
  // Set_Check to report it.
  function automatic int count_width(input int sets);
    return (sets < 1) ? 1 : $clog2(sets + 1);
  endfunction

endpackage

// File: rtl/Set_Check.sv
// Elaboration-time guard for the mXn family: rejects a SETS value below 1.
// Parameters: SETS - number of sets per packed word. No ports.
module Set_Check #(
  parameter int SETS = 1
) ();

  generate
    if (SETS < 1) begin : g_bad_sets
      $error("Set_Check: SETS must be >= 1, got %0d", SETS);
    end
  endgenerate

endmodule

// File: rtl/mxnbit_set_packer.sv
// Packs up to SETS incoming WIDTH-bit sets into one word for the mXn gate
// wrappers. A word closes when SETS sets have been taken or on in_last. It is
// then held on out_packed/out_count with out_valid until out_ready.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_set            - incoming set
//   in_valid, in_last - set valid, set closes the word early
//   in_ready          - high while collecting (FILL)
//   out_packed        - word; set i at [i*WIDTH +: WIDTH], unfilled slots 0
//   out_count         - number of sets in the word (1..SETS when valid)
//   out_valid         - word is complete (FULL)
//   out_ready         - consumer takes the word
module mxnbit_set_packer
  import mxnbit_set_packer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SETS  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              in_set,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [SETS*WIDTH-1:0]         out_packed,
  output logic [count_width(SETS)-1:0]  out_count,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int CW = count_width(SETS);

  Set_Check #(.SETS(SETS)) u_set_check ();

  state_t                 state, state_nxt;
  logic [SETS*WIDTH-1:0]  word_q, word_nxt;
  // idx doubles as the set count of the held word.
  logic [CW-1:0]          idx_q, idx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      state  <= state_nxt;
      word_q <= word_nxt;
      idx_q  <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word_q;
    idx_nxt   = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Slot select unrolled over constant offsets.
          for (int unsigned i = 0; i < SETS; i++) begin
            if (idx_q == CW'(i)) begin
              word_nxt[i*WIDTH +: WIDTH] = in_set;
            end
          end
          idx_nxt = idx_q + CW'(1);
          if ((idx_q == CW'(SETS - 1)) || in_last) begin
            state_nxt = FULL;
          end
        end
      end
      FULL: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // Clearing here keeps slots left empty by in_last at zero.
          word_nxt  = '0;
          idx_nxt   = '0;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  assign out_packed = word_q;
  assign out_count  = idx_q;

endmodule

// File: tb/tb_mxnbit_set_packer.sv
module tb_mxnbit_set_packer;

  localparam int W = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] in_set;
  logic         in_valid, in_last, out_ready;
  logic         in_ready, out_valid;
  logic [S*W-1:0] out_packed;
  logic [1:0]   out_count;

  logic [7:0]   b_in_set;
  logic         b_in_valid, b_in_last, b_out_ready;
  logic         b_in_ready, b_out_valid;
  logic [7:0]   b_out_packed;
  logic [0:0]   b_out_count;

  mxnbit_set_packer #(.WIDTH(W), .SETS(S)) dut (
    .clk(clk), .rst(rst), .in_set(in_set), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_packed(out_packed),
    .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
  );

  mxnbit_set_packer #(.WIDTH(8), .SETS(1)) dut1 (
    .clk(clk), .rst(rst), .in_set(b_in_set), .in_valid(b_in_valid),
    .in_last(b_in_last), .in_ready(b_in_ready), .out_packed(b_out_packed),
    .out_count(b_out_count), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the word under construction is a list of sets; once closed it
  // is held until the consumer takes it.
  int unsigned m_sets[$];
  bit          m_full;
  int          m_emit   = 0;
  int          dut_emit = 0;
  string       cur_tag  = "init";

  function automatic logic [63:0] m_word();
    logic [63:0] w = '0;
    foreach (m_sets[i]) w |= 64'(m_sets[i]) << (i * W);
    return w;
  endfunction

  task automatic m_edge();
    if (rst) begin
      m_sets.delete();
      m_full = 1'b0;
    end else if (m_full) begin
      if (out_ready) begin
        m_emit += m_sets.size();
        m_sets.delete();
        m_full = 1'b0;
      end
    end else if (in_valid) begin
      m_sets.push_back(int'(in_set));
      if (m_sets.size() == S || in_last) m_full = 1'b1;
    end
  endtask

  task automatic check_outs();
    check({cur_tag, "/in_ready"}, in_ready, !m_full);
    check({cur_tag, "/out_valid"}, out_valid, m_full);
    if (m_full) begin
      check({cur_tag, "/out_packed"}, out_packed, m_word());
      check({cur_tag, "/out_count"}, out_count, m_sets.size());
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at
  // the next falling edge.
  task automatic cyc(input logic v, input logic [W-1:0] s, input logic l,
                     input logic ordy, input logic r);
    rst = r; in_valid = v; in_set = s; in_last = l; out_ready = ordy;
    if (out_valid && out_ready && !r) dut_emit += int'(out_count);
    @(posedge clk);
    m_edge();
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_set = '0; in_last = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_set = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
    @(negedge clk);

    cur_tag = "reset";
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("reset/packed_zero", out_packed, 0);
    check("reset/count_zero", out_count, 0);
    check("reset/b_ready", b_in_ready, 1);

    cur_tag = "fill";
    cyc(1, 4'hA, 0, 0, 0);
    cyc(1, 4'h5, 0, 0, 0);
    check("fill/packed", out_packed, 8'h5A);
    check("fill/count", out_count, 2);
    check("fill/valid", out_valid, 1);
    check("fill/in_ready", in_ready, 0);

    cur_tag = "backpressure";
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'hF, 0, 0, 0);
      check("bp/packed_hold", out_packed, 8'h5A);
      check("bp/count_hold", out_count, 2);
    end
    cyc(1, 4'hF, 0, 1, 0);
    check("bp/cleared", out_packed, 0);
    check("bp/count_cleared", out_count, 0);

    cur_tag = "early";
    cyc(1, 4'h3, 1, 0, 0);
    check("early/packed", out_packed, 8'h03);
    check("early/count", out_count, 1);
    cyc(0, 0, 0, 1, 0);

    cur_tag = "rst_mid";
    cyc(1, 4'h7, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 4'h1, 0, 0, 0);
    cyc(1, 4'h2, 0, 0, 0);
    check("rst_mid/packed", out_packed, 8'h21);
    check("rst_mid/count", out_count, 2);
    cyc(0, 0, 0, 1, 0);

    cur_tag = "last_no_valid";
    cyc(0, 4'h9, 1, 0, 0);
    check("last_no_valid/in_ready", in_ready, 1);
    check("last_no_valid/count", out_count, 0);

    cur_tag = "soak";
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) == 0));
    end
    cur_tag = "drain";
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("soak/sets_emitted", dut_emit, m_emit);

    // SETS=1, WIDTH=8: every accepted set is a word, one word per two cycles.
    b_in_valid = 1'b1; b_in_set = 8'hC3; b_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("s1/valid0", b_out_valid, 1);
    check("s1/packed0", b_out_packed, 8'hC3);
    check("s1/count0", b_out_count, 1);
    b_in_set = 8'h3C;
    @(posedge clk); @(negedge clk);
    check("s1/gap_valid", b_out_valid, 0);
    check("s1/gap_ready", b_in_ready, 1);
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    check("s1/valid1", b_out_valid, 1);
    check("s1/packed1", b_out_packed, 8'h3C);
    check("s1/count1", b_out_count, 1);
    @(posedge clk); @(negedge clk);
    check("s1/drained", b_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
